// File: rtl/game_flow_ctrl.sv
// Round sequencer for the bubble game: IDLE/PLAY/PAUSE/WIN/LOSE, BCD score and round timer, score-row tiles.
// Define GAME_TIMER_EN to build in the countdown timer and timeout loss.
module game_flow_ctrl #(
  parameter int TILE_W       = 5,
  parameter int DARK_TILE    = 31,
  parameter int SCORE_TARGET = 20,
  parameter int TIME_LIMIT   = 60
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                pause,
  input  logic                tick,
  input  logic                score_inc,
  input  logic                bubble_full,
  output logic [2:0]          state,
  output logic                playing,
  output logic                win,
  output logic                lose,
  output logic [15:0]         score_bcd,
  output logic [7:0]          time_bcd,
  output logic [8*TILE_W-1:0] score_row
);

  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, PAUSE = 3'd2, WIN = 3'd3, LOSE = 3'd4} state_t;

`ifdef GAME_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  function automatic logic [15:0] to_bcd16(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] to_bcd8(input int v);
    return {4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  localparam logic [15:0]       TARGET_BCD = to_bcd16(SCORE_TARGET);
  localparam logic [7:0]        LIMIT_BCD  = to_bcd8(TIME_LIMIT);
  localparam logic [TILE_W-1:0] DARK       = TILE_W'(DARK_TILE);

  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        c;
    r = s;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Leading-zero blanking on the score; time tiles only exist with the timer.
  function automatic logic [8*TILE_W-1:0] row_of(input logic [15:0] s, input logic [7:0] t);
    logic [8*TILE_W-1:0] r;
    r = {8{DARK}};
    r[0 +: TILE_W] = TILE_W'(s[3:0]);
    if (s[15:4]  != 12'd0) r[1*TILE_W +: TILE_W] = TILE_W'(s[7:4]);
    if (s[15:8]  != 8'd0)  r[2*TILE_W +: TILE_W] = TILE_W'(s[11:8]);
    if (s[15:12] != 4'd0)  r[3*TILE_W +: TILE_W] = TILE_W'(s[15:12]);
    if (TIMER_ON) begin
      r[6*TILE_W +: TILE_W] = TILE_W'(t[3:0]);
      r[7*TILE_W +: TILE_W] = TILE_W'(t[7:4]);
    end
    return r;
  endfunction

  function automatic logic [2:0] flags_of(input state_t s);
    return {s == PLAY, s == WIN, s == LOSE};
  endfunction

  state_t      st;
  logic        en_q, pause_q;
  logic        start_e, pause_e, timeout;
  logic [15:0] score_nxt;
  logic [7:0]  time_nxt;

  assign state   = st;
  assign start_e = en & ~en_q;
  assign pause_e = pause & ~pause_q;
  assign timeout = TIMER_ON && (time_bcd == 8'h00);

  // Datapath updates key off the current state, so a tick or score pulse
  // arriving with a PLAY-exit condition still lands.
  always_comb begin
    score_nxt = score_bcd;
    time_nxt  = time_bcd;
    if (st == IDLE && start_e) begin
      score_nxt = 16'h0000;
      time_nxt  = LIMIT_BCD;
    end else if (st == PLAY) begin
      if (score_inc && score_bcd != 16'h9999) score_nxt = bcd_inc(score_bcd);
      if (TIMER_ON && tick && time_bcd != 8'h00)
        time_nxt = (time_bcd[3:0] == 4'd0) ? {time_bcd[7:4] - 4'd1, 4'd9}
                                           : {time_bcd[7:4], time_bcd[3:0] - 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st                   <= IDLE;
      {playing, win, lose} <= 3'b000;
      en_q                 <= 1'b1;
      pause_q              <= 1'b1;
      score_bcd            <= 16'h0000;
      time_bcd             <= LIMIT_BCD;
      score_row            <= row_of(16'h0000, LIMIT_BCD);
    end else begin
      en_q      <= en;
      pause_q   <= pause;
      score_bcd <= score_nxt;
      time_bcd  <= time_nxt;
      score_row <= row_of(score_nxt, time_nxt);
      case (st)
        IDLE: if (start_e) begin
          st <= PLAY; {playing, win, lose} <= flags_of(PLAY);
        end
        PLAY: begin
          if (bubble_full || (score_bcd != TARGET_BCD && timeout)) begin
            st <= LOSE; {playing, win, lose} <= flags_of(LOSE);
          end else if (score_bcd == TARGET_BCD) begin
            st <= WIN; {playing, win, lose} <= flags_of(WIN);
          end else if (pause_e) begin
            st <= PAUSE; {playing, win, lose} <= flags_of(PAUSE);
          end
        end
        PAUSE: begin
          if (start_e) begin
            st <= IDLE; {playing, win, lose} <= flags_of(IDLE);
          end else if (pause_e) begin
            st <= PLAY; {playing, win, lose} <= flags_of(PLAY);
          end
        end
        WIN, LOSE: if (start_e) begin
          st <= IDLE; {playing, win, lose} <= flags_of(IDLE);
        end
        default: begin
          st <= IDLE; {playing, win, lose} <= flags_of(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: vector table for the state/score flow plus
// hand sequences for reset, timer, mid-round reset and BCD carry/blanking.
module tb_game_flow_ctrl;

  localparam int TW = 5;
  localparam logic [TW-1:0] D = 5'd31;

  logic clk = 1'b0;
  logic rst_n, en, pause, tick, score_inc, bubble_full;
  logic [2:0] a_state, b_state;
  logic a_playing, a_win, a_lose, b_playing, b_win, b_lose;
  logic [15:0] a_score, b_score;
  logic [7:0] a_time, b_time;
  logic [8*TW-1:0] a_row, b_row;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  game_flow_ctrl #(.TILE_W(TW), .DARK_TILE(31), .SCORE_TARGET(3), .TIME_LIMIT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pause(pause), .tick(tick), .score_inc(score_inc),
    .bubble_full(bubble_full), .state(a_state), .playing(a_playing), .win(a_win), .lose(a_lose),
    .score_bcd(a_score), .time_bcd(a_time), .score_row(a_row));

  game_flow_ctrl #(.TILE_W(TW), .DARK_TILE(31), .SCORE_TARGET(200), .TIME_LIMIT(60)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pause(pause), .tick(tick), .score_inc(score_inc),
    .bubble_full(bubble_full), .state(b_state), .playing(b_playing), .win(b_win), .lose(b_lose),
    .score_bcd(b_score), .time_bcd(b_time), .score_row(b_row));

`ifdef GAME_TIMER_EN
  localparam logic [TW-1:0] A7 = 5'd0, A6 = 5'd2, B7 = 5'd6, B6 = 5'd0;
`else
  localparam logic [TW-1:0] A7 = D, A6 = D, B7 = D, B6 = D;
`endif

  typedef struct {
    logic en, pause, tick, inc, bub;
    logic [2:0] st;
    logic [15:0] sc;
    logic pl, wn, ls;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic e, p, t, i, b, input logic [2:0] s,
                              input logic [15:0] sc, input logic pl, wn, ls);
    vec_t v;
    v.en = e; v.pause = p; v.tick = t; v.inc = i; v.bub = b;
    v.st = s; v.sc = sc; v.pl = pl; v.wn = wn; v.ls = ls;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, p, t, i, b);
    en = e; pause = p; tick = t; score_inc = i; bubble_full = b;
  endtask

  localparam logic [2:0] I = 3'd0, P = 3'd1, Z = 3'd2, W = 3'd3, L = 3'd4;

  initial begin
    // en, pause, tick, inc, bubble -> state, score, playing, win, lose  (time stays 02)
    vt.push_back(mk(1,0,0,0,0, I, 16'h0, 0,0,0));
    vt.push_back(mk(0,0,0,0,0, I, 16'h0, 0,0,0));
    vt.push_back(mk(1,0,0,0,0, P, 16'h0, 1,0,0));
    vt.push_back(mk(1,0,0,1,0, P, 16'h1, 1,0,0));
    vt.push_back(mk(1,0,0,0,0, P, 16'h1, 1,0,0));
    vt.push_back(mk(1,0,0,1,0, P, 16'h2, 1,0,0));
    vt.push_back(mk(1,0,0,1,0, P, 16'h3, 1,0,0));
    vt.push_back(mk(1,0,0,0,0, W, 16'h3, 0,1,0));
    vt.push_back(mk(1,0,0,1,0, W, 16'h3, 0,1,0));
    vt.push_back(mk(0,0,0,0,0, W, 16'h3, 0,1,0));
    vt.push_back(mk(1,0,0,0,0, I, 16'h3, 0,0,0));
    vt.push_back(mk(0,0,0,0,0, I, 16'h3, 0,0,0));
    vt.push_back(mk(1,0,0,0,0, P, 16'h0, 1,0,0));
    vt.push_back(mk(0,0,0,1,0, P, 16'h1, 1,0,0));
    vt.push_back(mk(0,0,0,1,0, P, 16'h2, 1,0,0));
    vt.push_back(mk(0,0,0,1,1, L, 16'h3, 0,0,1));
    vt.push_back(mk(0,0,0,0,0, L, 16'h3, 0,0,1));
    vt.push_back(mk(1,0,0,0,0, I, 16'h3, 0,0,0));
    vt.push_back(mk(0,0,0,0,0, I, 16'h3, 0,0,0));
    vt.push_back(mk(1,0,0,0,0, P, 16'h0, 1,0,0));
    vt.push_back(mk(0,0,0,1,0, P, 16'h1, 1,0,0));
    vt.push_back(mk(0,0,0,1,0, P, 16'h2, 1,0,0));
    vt.push_back(mk(0,0,0,1,0, P, 16'h3, 1,0,0));
    vt.push_back(mk(0,0,0,0,1, L, 16'h3, 0,0,1));
    vt.push_back(mk(1,0,0,0,0, I, 16'h3, 0,0,0));
    vt.push_back(mk(0,0,0,0,0, I, 16'h3, 0,0,0));
    vt.push_back(mk(1,0,0,0,0, P, 16'h0, 1,0,0));
    vt.push_back(mk(0,0,0,1,0, P, 16'h1, 1,0,0));
    vt.push_back(mk(0,1,0,0,0, Z, 16'h1, 0,0,0));
    vt.push_back(mk(0,1,1,1,0, Z, 16'h1, 0,0,0));
    vt.push_back(mk(0,0,1,1,0, Z, 16'h1, 0,0,0));
    vt.push_back(mk(0,1,0,0,0, P, 16'h1, 1,0,0));
    vt.push_back(mk(0,0,0,0,0, P, 16'h1, 1,0,0));
    vt.push_back(mk(0,1,0,0,0, Z, 16'h1, 0,0,0));
    vt.push_back(mk(0,0,0,0,0, Z, 16'h1, 0,0,0));
    vt.push_back(mk(1,1,0,0,0, I, 16'h1, 0,0,0));

    // Reset with en held high: no start edge on release.
    rst_n = 1'b0;
    drive(1,0,0,0,0);
    repeat (3) step();
    chk("reset_regs", {a_state, a_score, a_time, a_playing, a_win, a_lose},
        {I, 16'h0, 8'h02, 3'b000});
    chk("reset_row", a_row, {A7, A6, D, D, D, D, D, 5'd0});
    rst_n = 1'b1;
    step();
    chk("release_en_high", {a_state, a_playing}, {I, 1'b0});
    chk("release_row", a_row, {A7, A6, D, D, D, D, D, 5'd0});

    foreach (vt[k]) begin
      drive(vt[k].en, vt[k].pause, vt[k].tick, vt[k].inc, vt[k].bub);
      step();
      chk($sformatf("vec%0d", k), {a_state, a_score, a_time, a_playing, a_win, a_lose},
          {vt[k].st, vt[k].sc, 8'h02, vt[k].pl, vt[k].wn, vt[k].ls});
    end

    // Mid-round reset overrides PLAY within one cycle.
    drive(0,0,0,0,0); step();
    drive(1,0,0,0,0); step();
    drive(0,0,0,1,0); step();
    chk("pre_reset_play", {a_state, a_score}, {P, 16'h1});
    drive(0,0,0,0,0);
    rst_n = 1'b0; step();
    chk("mid_round_reset", {a_state, a_score, a_time, a_playing}, {I, 16'h0, 8'h02, 1'b0});
    rst_n = 1'b1; step();

    // Timer run: two ticks in PLAY.
    drive(1,0,0,0,0); step();
    chk("timer_start", {a_state, a_time}, {P, 8'h02});
    drive(0,0,1,0,0); step();
`ifdef GAME_TIMER_EN
    chk("tick1", a_time, 8'h01);
    step();
    chk("tick2", {a_state, a_time}, {P, 8'h00});
    drive(0,0,0,0,0); step();
    chk("timeout_lose", {a_state, a_lose, a_win}, {L, 1'b1, 1'b0});
    chk("timeout_row", a_row, {5'd0, 5'd0, D, D, D, D, D, 5'd0});
    drive(0,0,1,0,0); step();
    chk("tick_after_lose", a_time, 8'h00);
`else
    chk("tick1_ignored", a_time, 8'h02);
    step();
    drive(0,0,0,0,0); step();
    chk("no_timeout", {a_state, a_time}, {P, 8'h02});
    chk("no_time_row", a_row, {D, D, D, D, D, D, D, 5'd0});
`endif

    // BCD carry and leading-zero blanking on dut_b.
    drive(0,0,0,0,0);
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    drive(1,0,0,0,0); step();
    drive(0,0,0,1,0);
    repeat (99) step();
    drive(0,0,0,0,0); step();
    chk("score_99", {b_state, b_score}, {P, 16'h0099});
    chk("row_99", b_row, {B7, B6, D, D, D, D, 5'd9, 5'd9});
    drive(0,0,0,1,0); step();
    drive(0,0,0,0,0); step();
    chk("score_100", b_score, 16'h0100);
    chk("row_100", b_row, {B7, B6, D, D, D, 5'd1, 5'd0, 5'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
